fxp_op_sequencer: RTL and testbench
===================================

# fxp_op_sequencer

Sequencer that sits between a request source and the Q-format fixed-point arithmetic units (adder, multiplier, multi-cycle divider). It accepts one operation at a time over a valid/ready request channel, drives operands to the selected unit, and pulses the divider's start. It waits for the divider's completion, then returns the result with its tag over a valid/ready response channel. It replaces ad-hoc per-clock opcode muxing with a defined handshake, error reporting and a divider watchdog.

## Interface
- `WIDTH`, 32: operand/result width, sign-magnitude fixed point (MSB = sign).
- `TAG_W`, 4: request tag width.
- `DIV_TIMEOUT`, 64: max cycles waiting for `div_complete` before error.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` / `req_ready` in/out 1: request handshake.
- `req_opcode` in 2: 00 add, 01 mul, 10 div, 11 reserved.
- `req_a`, `req_b` in WIDTH: operands (b = divisor).
- `req_tag` in TAG_W: returned unchanged on response.
- `resp_valid` / `resp_ready` out/in 1: response handshake.
- `resp_data` out WIDTH; `resp_tag` out TAG_W; `resp_err` out 1.
- `op_a`, `op_b` out WIDTH: registered operands to all units.
- `add_result`, `mul_result` in WIDTH: combinational unit outputs.
- `div_start` out 1; `div_complete` in 1; `div_quotient` in WIDTH.
- `busy` out 1: high in any state but IDLE.

## Operation
- States: IDLE, EXEC, DIV_START, DIV_WAIT, RESP.
- IDLE: `req_ready`=1. On accept, latch opcode, tag, `op_a`, `op_b`.
  - Add/mul -> EXEC.
  - Div with divisor magnitude (`req_b[WIDTH-2:0]`) zero -> RESP, err=1, data=0; no `div_start`.
  - Div otherwise -> DIV_START.
  - Opcode 11 -> RESP, err=1, data=0.
- EXEC: capture `add_result`/`mul_result` per latched opcode -> RESP, err=0.
- DIV_START: `div_start`=1 for exactly this cycle; clear watchdog -> DIV_WAIT.
- DIV_WAIT: watchdog increments each cycle.
  - On `div_complete`=1: capture `div_quotient`, err=0 -> RESP. Completion has priority over timeout in the same cycle.
  - On watchdog reaching DIV_TIMEOUT-1 without completion: err=1, data=0 -> RESP.
- RESP: `resp_valid`=1, data/tag/err stable until `resp_ready`; on handshake -> IDLE.
- `req_ready`=0 outside IDLE; requests are never dropped, only stalled.
- `div_complete` outside DIV_WAIT is ignored, including a late completion after a timeout.
- Reset, including mid-operation: state IDLE. All outputs 0 except `req_ready`=1. Any in-flight op is discarded with no response.

## Timing
- Accept edge = T. Add/mul: EXEC during cycle T+1, `resp_valid` high from T+2.
- Div: `div_start` high during T+1. Completion sampled at edge E -> `resp_valid` from E+1.
- Timeout: `resp_valid` at T+2+DIV_TIMEOUT.
- Error fast path (zero divisor or reserved opcode): `resp_valid` from T+1.
- After the response handshake edge, `req_ready`=1 in the next cycle. Minimum cadence is 3 cycles/op for add/mul.
- `op_a`/`op_b` hold from the accept edge until the next accept.

## Structure
- Shared package `fxp_pkg`:
  - opcode enum (OP_ADD, OP_MUL, OP_DIV, OP_RSVD);
  - sequencer state enum;
  - localparam default WIDTH and fraction bits (23).
- One sub-module: `fxp_div_watchdog`, a clearable, enabled counter with a `expired` output, parameterised by DIV_TIMEOUT.

## Test plan
- Add 0x00800000 + 0x00C00000 with tag 3, adder model returning 0x01400000 -> resp data 0x01400000, tag 3, err 0, `resp_valid` at T+2.
- Div 0x01000000 / 0x00800000, divider model completing 10 cycles after start with 0x01000000 -> one-cycle `div_start`, resp 0x01000000, err 0.
- Div by 0x80000000 (negative zero) -> no `div_start`, resp err 1, data 0 at T+1; opcode 11 -> same response.
- Divider never completes, DIV_TIMEOUT=8 -> err 1 at T+10. A late `div_complete` is ignored and the next add proceeds normally.
- `resp_ready` held low 5 cycles -> resp held stable and `req_ready` stays 0. Back-to-back add/mul requests -> all tags returned in order.
- `rst_n` low during DIV_WAIT -> next cycle IDLE, `req_ready`=1, `resp_valid`=0, `div_start`=0. A stray `div_complete` after reset produces no response.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point operation sequencer: opcode and
// sequencer state encodings, default datapath width and fraction bits.
package fxp_pkg;

  localparam int FXP_WIDTH     = 32;
  localparam int FXP_FRAC_BITS = 23;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } fxp_opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_DIV_START = 3'd2,
    ST_DIV_WAIT  = 3'd3,
    ST_RESP      = 3'd4
  } seq_state_e;

  // Raw request opcode bits to the enum used throughout the sequencer.
  function automatic fxp_opcode_e to_opcode(input logic [1:0] raw);
    return fxp_opcode_e'(raw);
  endfunction

endpackage

// File: rtl/fxp_op_sequencer_if.sv
// Request/response channels between a request source (master) and the
// operation sequencer (slave). Both channels use valid/ready handshakes.
interface fxp_op_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, resp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, resp_err
  );

endinterface

// File: rtl/fxp_div_watchdog.sv
// Divider watchdog: clearable counter that advances while enabled and
// flags expiry once it has reached DIV_TIMEOUT-1. It saturates there so a
// long enable never wraps back into a "not expired" value.
module fxp_div_watchdog #(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DIV_TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  assign expired = (count_reg == LIMIT);

  // Count cycles spent waiting; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fxp_op_sequencer.sv
// Sequences one fixed-point operation at a time: accepts a request, drives
// registered operands to the add/mul/div units, waits for the divider (with
// a watchdog), and returns the result plus tag on the response channel.
module fxp_op_sequencer
  import fxp_pkg::*;
#(
  parameter int WIDTH       = FXP_WIDTH,
  parameter int TAG_W       = 4,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  fxp_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] add_result,
  input  logic [WIDTH-1:0] mul_result,
  output logic             div_start,
  input  logic             div_complete,
  input  logic [WIDTH-1:0] div_quotient,
  output logic             busy
);

  seq_state_e       state_reg,  state_next;
  fxp_opcode_e      opcode_reg, opcode_next;
  logic [TAG_W-1:0] tag_reg,    tag_next;
  logic [WIDTH-1:0] op_a_reg,   op_a_next;
  logic [WIDTH-1:0] op_b_reg,   op_b_next;
  logic [WIDTH-1:0] data_reg,   data_next;
  logic             err_reg,    err_next;

  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expired;
  fxp_opcode_e req_op;

  assign req_op = to_opcode(bus.req_opcode);

  fxp_div_watchdog #(
    .DIV_TIMEOUT (DIV_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      opcode_reg <= OP_ADD;
      tag_reg    <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      data_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      opcode_reg <= opcode_next;
      tag_reg    <= tag_next;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      data_reg   <= data_next;
      err_reg    <= err_next;
    end
  end

  // Next-state and datapath capture; every register holds unless updated.
  always_comb begin
    state_next  = state_reg;
    opcode_next = opcode_reg;
    tag_next    = tag_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    data_next   = data_reg;
    err_next    = err_reg;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          opcode_next = req_op;
          tag_next    = bus.req_tag;
          op_a_next   = bus.req_a;
          op_b_next   = bus.req_b;
          case (req_op)
            OP_ADD, OP_MUL: state_next = ST_EXEC;
            OP_DIV: begin
              // Sign bit is ignored: +0 and -0 are both a zero divisor.
              if (bus.req_b[WIDTH-2:0] == '0) begin
                data_next  = '0;
                err_next   = 1'b1;
                state_next = ST_RESP;
              end else begin
                state_next = ST_DIV_START;
              end
            end
            default: begin
              data_next  = '0;
              err_next   = 1'b1;
              state_next = ST_RESP;
            end
          endcase
        end
      end

      ST_EXEC: begin
        data_next  = (opcode_reg == OP_MUL) ? mul_result : add_result;
        err_next   = 1'b0;
        state_next = ST_RESP;
      end

      ST_DIV_START: begin
        wd_clear   = 1'b1;
        state_next = ST_DIV_WAIT;
      end

      ST_DIV_WAIT: begin
        wd_enable = 1'b1;
        // Completion wins over a watchdog expiry in the same cycle.
        if (div_complete) begin
          data_next  = div_quotient;
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else if (wd_expired) begin
          data_next  = '0;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_data  = data_reg;
  assign bus.resp_tag   = tag_reg;
  assign bus.resp_err   = err_reg;
  assign div_start      = (state_reg == ST_DIV_START);
  assign busy           = (state_reg != ST_IDLE);
  assign op_a           = op_a_reg;
  assign op_b           = op_b_reg;

endmodule

// File: tb/tb_fxp_op_sequencer.sv
// Bench for fxp_op_sequencer: behavioural add/mul/div unit models, a
// reference model derived from the operation/timing rules, directed cases
// followed by randomized operations.
module tb_fxp_op_sequencer;
  import fxp_pkg::*;

  localparam int WIDTH  = 32;
  localparam int TAG_W  = 4;
  localparam int DIV_TO = 12;
  localparam int FRAC   = FXP_FRAC_BITS;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] op_a, op_b, add_result, mul_result, div_quotient;
  logic             div_start, div_complete, busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int starts      = 0;
  int div_lat     = 1;
  bit div_pending = 0;
  int div_cnt     = 0;
  logic [31:0] div_q = '0;
  bit stray_complete = 0;

  fxp_op_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  fxp_op_sequencer #(
    .WIDTH       (WIDTH),
    .TAG_W       (TAG_W),
    .DIV_TIMEOUT (DIV_TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .op_a         (op_a),
    .op_b         (op_b),
    .add_result   (add_result),
    .mul_result   (mul_result),
    .div_start    (div_start),
    .div_complete (div_complete),
    .div_quotient (div_quotient),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit models: sign-magnitude Q8.23 style arithmetic in plain integers.
  function automatic logic [31:0] unit_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [31:0] unit_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = (64'(a[30:0]) * 64'(b[30:0])) >> FRAC;
    return {a[31] ^ b[31], p[30:0]};
  endfunction

  function automatic logic [31:0] unit_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] q;
    if (b[30:0] == '0) return '0;
    q = (64'(a[30:0]) << FRAC) / 64'(b[30:0]);
    return {a[31] ^ b[31], q[30:0]};
  endfunction

  assign add_result = unit_add(op_a, op_b);
  assign mul_result = unit_mul(op_a, op_b);

  // Divider model: completes div_lat cycles after the start cycle.
  initial begin
    div_complete = 1'b0;
    div_quotient = '0;
    forever begin
      @(posedge clk);
      #1;
      div_complete = stray_complete;
      if (div_pending) begin
        if (div_cnt == 0) begin
          div_complete = 1'b1;
          div_quotient = div_q;
          div_pending  = 0;
        end else begin
          div_cnt = div_cnt - 1;
        end
      end
      if (div_start) begin
        starts++;
        div_pending = 1;
        div_cnt     = div_lat - 1;
        div_q       = unit_div(op_a, op_b);
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: expected result, error flag, response offset (cycles from
  // the accept edge to the first cycle resp_valid is seen) and start count.
  task automatic ref_model(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                           input int lat, output logic [31:0] data, output logic err,
                           output int off, output int n_starts);
    data = '0; err = 1'b1; off = 0; n_starts = 0;
    if (opc == 2'b00) begin
      data = unit_add(a, b); err = 1'b0; off = 1;
    end else if (opc == 2'b01) begin
      data = unit_mul(a, b); err = 1'b0; off = 1;
    end else if (opc == 2'b10 && b[30:0] != '0) begin
      n_starts = 1;
      if (lat <= DIV_TO) begin
        data = unit_div(a, b); err = 1'b0; off = lat + 1;
      end else begin
        off = DIV_TO + 1;
      end
    end
  endtask

  // Issue one request at a negedge, check the response, then handshake it.
  task automatic run_op(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input int lat, input int hold, output int acc);
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_off, exp_starts, s0, w;
    ref_model(opc, a, b, lat, exp_d, exp_e, exp_off, exp_starts);
    div_lat = lat;
    bus.req_valid = 1'b1; bus.req_opcode = opc; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_val("req_ready", 64'(bus.req_ready), 1);
    acc = cyc + 1;
    s0  = starts;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    check_val("op_a", 64'(op_a), 64'(a));
    check_val("op_b", 64'(op_b), 64'(b));
    w = 0;
    while (bus.resp_valid !== 1'b1 && w < DIV_TO + 20) begin
      @(negedge clk);
      w++;
    end
    check_val("resp_valid", 64'(bus.resp_valid), 1);
    check_val("resp_lat", 64'(cyc - acc), 64'(exp_off));
    check_val("resp_data", 64'(bus.resp_data), 64'(exp_d));
    check_val("resp_tag", 64'(bus.resp_tag), 64'(tag));
    check_val("resp_err", 64'(bus.resp_err), 64'(exp_e));
    check_val("div_starts", 64'(starts - s0), 64'(exp_starts));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_valid", 64'(bus.resp_valid), 1);
      check_val("hold_data", 64'(bus.resp_data), 64'(exp_d));
      check_val("hold_tag", 64'(bus.resp_tag), 64'(tag));
      check_val("hold_err", 64'(bus.resp_err), 64'(exp_e));
      check_val("hold_req_ready", 64'(bus.req_ready), 0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_val("resp_drop", 64'(bus.resp_valid), 0);
    check_val("ready_back", 64'(bus.req_ready), 1);
  endtask

  // Directed cases, reset-in-flight case, then random operations.
  initial begin
    int acc, prev;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_tag = '0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 64'(bus.req_ready), 1);
    check_val("rst_resp_valid", 64'(bus.resp_valid), 0);
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_div_start", 64'(div_start), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'h0080_0000, 32'h00C0_0000, 4'd3, 1, 0, acc);
    run_op(2'b10, 32'h0100_0000, 32'h0080_0000, 4'd5, 10, 0, acc);
    run_op(2'b10, 32'h0123_4567, 32'h8000_0000, 4'd6, 1, 0, acc);
    run_op(2'b11, 32'h0123_4567, 32'h0080_0000, 4'd7, 1, 0, acc);
    run_op(2'b10, 32'h0300_0000, 32'h0080_0000, 4'd1, DIV_TO, 0, acc);
    run_op(2'b10, 32'h0300_0000, 32'h0080_0000, 4'd2, DIV_TO + 1, 0, acc);
    div_pending = 0;
    run_op(2'b10, 32'h0100_0000, 32'h0080_0000, 4'd8, 1000, 0, acc);
    div_pending = 0;
    // Late completion while idle must not produce a response.
    stray_complete = 1;
    @(negedge clk);
    stray_complete = 0;
    repeat (3) begin
      @(negedge clk);
      check_val("late_cpl_valid", 64'(bus.resp_valid), 0);
      check_val("late_cpl_busy", 64'(busy), 0);
    end
    run_op(2'b00, 32'h0011_0000, 32'h0022_0000, 4'd4, 1, 5, acc);

    prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_op(2'(k % 2), $urandom, $urandom, 4'(9 + k), 1, 0, acc);
      if (k > 0) check_val("cadence", 64'(acc - prev), 3);
      prev = acc;
    end

    // Reset while waiting on the divider.
    div_lat = 1000;
    bus.req_valid = 1'b1; bus.req_opcode = 2'b10;
    bus.req_a = 32'h0100_0000; bus.req_b = 32'h0080_0000; bus.req_tag = 4'd13;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_val("busy_divwait", 64'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_req_ready", 64'(bus.req_ready), 1);
    check_val("mid_rst_resp_valid", 64'(bus.resp_valid), 0);
    check_val("mid_rst_div_start", 64'(div_start), 0);
    check_val("mid_rst_busy", 64'(busy), 0);
    check_val("mid_rst_op_a", 64'(op_a), 0);
    rst_n = 1'b1;
    div_pending = 0;
    stray_complete = 1;
    @(negedge clk);
    stray_complete = 0;
    repeat (4) begin
      @(negedge clk);
      check_val("post_rst_valid", 64'(bus.resp_valid), 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  opc;
      logic [31:0] a, b;
      opc = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) b = {b[31], 31'b0};
      run_op(opc, a, b, 4'(i), $urandom_range(1, DIV_TO + 3), $urandom_range(0, 2), acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
